// File: rtl/audio_sample_engine.sv
// audio_sample_engine: internal sample-tick generator, ADC conversion sequencer,
// delay-line RAM and output processing (pass / delay / echo / mute).
module audio_sample_engine #(
  parameter int DW  = 10,
  parameter int AW  = 13,
  parameter int DIV = 5000,
  parameter int TMO = 4000
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] delay_len,
  output logic          adc_start,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  output logic [DW-1:0] dac_data,
  output logic          dac_load,
  output logic          busy,
  output logic          overrun,
  output logic [15:0]   sample_cnt
);

  localparam int CW   = $clog2(DIV);
  localparam int TW   = $clog2(TMO);
  localparam int MIDI = 2 ** (DW - 1);

  localparam logic [DW-1:0]        MID   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [AW:0]          DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0]        LAST  = CW'(DIV - 1);
  localparam logic [TW-1:0]        TLAST = TW'(TMO - 1);
  localparam logic signed [DW+1:0] SMAX  = (DW+2)'(MIDI - 1);
  localparam logic signed [DW+1:0] SMIN  = (DW+2)'(-MIDI);
  localparam logic signed [DW+1:0] SMID  = (DW+2)'(MIDI);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_CALC,
    ST_WRITE
  } state_t;

  state_t state;
  state_t next_state;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  logic [1:0]    mode_q;
  logic [AW-1:0] len_q;
  logic [DW-1:0] x_q;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] wb_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   prefill;

  logic [DW-1:0] ram [2**AW];

  logic [DW-1:0]        d_val;
  logic signed [DW+1:0] xs;
  logic signed [DW+1:0] ds;
  logic signed [DW+1:0] s_sum;
  logic signed [DW+1:0] s_sat;
  logic [DW-1:0]        echo_y;
  logic [DW-1:0]        y_val;
  logic [DW-1:0]        store_val;

  assign tick    = enable && (tick_cnt == LAST);
  assign tmo_hit = (tmo_cnt == TLAST);
  assign busy    = (state != ST_IDLE);
  assign rd_addr = wr_ptr - len_q;

  // Free-running sample tick divider, held at zero while disabled
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!enable || tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state: one conversion per tick, then read, compute and write back
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (tick) next_state = ST_WAIT;
      ST_WAIT: begin
        if (adc_valid) begin
          next_state = ST_READ;
        end else if (tmo_hit) begin
          next_state = ST_IDLE;
        end
      end
      ST_READ:  next_state = ST_CALC;
      ST_CALC:  next_state = ST_WRITE;
      ST_WRITE: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Delay line storage; contents deliberately left unreset
  always_ff @(posedge sysclk) begin
    if (state == ST_WRITE) begin
      ram[wr_ptr] <= wb_q;
    end
    if (state == ST_READ) begin
      rd_q <= ram[rd_addr];
    end
  end

  // Sample processing: mid-scale substitute during prefill, signed echo with saturation
  always_comb begin
    d_val     = (prefill < {1'b0, len_q}) ? MID : rd_q;
    xs        = $signed({2'b00, x_q}) - SMID;
    ds        = $signed({2'b00, d_val}) - SMID;
    s_sum     = xs + (ds >>> 1);
    s_sat     = s_sum;
    if (s_sum > SMAX) begin
      s_sat = SMAX;
    end else if (s_sum < SMIN) begin
      s_sat = SMIN;
    end
    echo_y    = DW'(s_sat + SMID);
    y_val     = x_q;
    store_val = x_q;
    case (mode_q)
      2'b01: y_val = d_val;
      2'b10: begin
        y_val     = echo_y;
        store_val = echo_y;
      end
      2'b11: y_val = MID;
      default: y_val = x_q;
    endcase
  end

  // Datapath registers, handshake pulses, counters and sticky overrun flag
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      adc_start  <= 1'b0;
      dac_load   <= 1'b0;
      dac_data   <= MID;
      overrun    <= 1'b0;
      sample_cnt <= '0;
      wr_ptr     <= '0;
      prefill    <= '0;
      tmo_cnt    <= '0;
      mode_q     <= '0;
      len_q      <= AW'(1);
      x_q        <= MID;
      wb_q       <= MID;
    end else begin
      adc_start <= 1'b0;
      dac_load  <= 1'b0;
      if (tick && state != ST_IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (tick) begin
            mode_q    <= mode;
            len_q     <= (delay_len == '0) ? AW'(1) : delay_len;
            adc_start <= 1'b1;
            tmo_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (adc_valid) begin
            x_q <= adc_data;
          end else if (tmo_hit) begin
            overrun <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_CALC: begin
          dac_data   <= y_val;
          dac_load   <= 1'b1;
          sample_cnt <= sample_cnt + 16'd1;
          wb_q       <= store_val;
        end
        ST_WRITE: begin
          wr_ptr <= wr_ptr + AW'(1);
          if (prefill != DEPTH) begin
            prefill <= prefill + (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
